// File: rtl/nibble_word_packer_if.sv
// Handshake bundle between a nibble producer, the packer and the packed-word consumer.
// The packer sits on the slave modport; the environment that drives it uses master.
interface nibble_word_packer_if #(
  parameter int NW    = 4,
  parameter int NPW   = 4,
  parameter int CNT_W = 64
);
  localparam int WORD_W = NPW * NW;
  localparam int LEN_W  = $clog2(NPW + 1);

  logic              in_valid;
  logic              in_ready;
  logic [NW-1:0]     in_nibble;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [LEN_W-1:0]  out_len;
  logic              out_xz;
  logic [CNT_W-1:0]  word_count;

  modport master (
    output in_valid, in_nibble, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_len, out_xz, word_count
  );

  modport slave (
    input  in_valid, in_nibble, in_last, out_ready,
    output in_ready, out_valid, out_word, out_len, out_xz, word_count
  );
endinterface

// File: rtl/nibble_word_packer.sv
// Packs a nibble stream into [0:3][3:0] words (element 0 in the top bits), with a
// two-entry output FIFO and a wrapping count of delivered words.
module nibble_word_packer #(
  parameter int NPW   = 4,
  parameter int NW    = 4,
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_word_packer_if.slave  bus
);
  localparam int WORD_W = NPW * NW;
  localparam int IDX_W  = $clog2(NPW);
  localparam int LEN_W  = $clog2(NPW + 1);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_next;
  logic [LEN_W-1:0]  len_next;

  logic [WORD_W-1:0] mem_word [2];
  logic [LEN_W-1:0]  mem_len  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_cnt;
  logic [CNT_W-1:0]  word_cnt_q;

  logic in_ready;
  logic accept;
  logic complete;
  logic push;
  logic pop;
  logic head_vld;
  logic [WORD_W-1:0] head_word;
  logic [LEN_W-1:0]  head_len;

  // Inserts a nibble into element k; other elements are passed through untouched,
  // so X/Z bits survive bit-exact and still-empty elements stay zero.
  function automatic logic [WORD_W-1:0] place_nibble(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  k,
    input logic [NW-1:0]     nib
  );
    logic [WORD_W-1:0] r;
    r = w;
    for (int e = 0; e < NPW; e++) begin
      if (k == IDX_W'(e)) r[WORD_W-1-NW*e -: NW] = nib;
    end
    return r;
  endfunction

  // in_ready depends only on local state, never on out_ready.
  assign in_ready = !rst && (fifo_cnt != 2'd2);
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && (bus.in_last || (idx_q == IDX_W'(NPW - 1)));
  assign push     = complete;
  assign head_vld = (fifo_cnt != 2'd0);
  assign pop      = head_vld && bus.out_ready;

  assign asm_next = place_nibble(asm_q, idx_q, bus.in_nibble);
  assign len_next = LEN_W'(idx_q) + LEN_W'(1);

  // Assembly stage: nibble into the working word
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      if (complete) begin
        idx_q <= '0;
        asm_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
        asm_q <= asm_next;
      end
    end
  end

  // Buffer stage: finished words queue here while the consumer stalls
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= asm_next;
      mem_len[wr_ptr]  <= len_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else if (pop) begin
      word_cnt_q <= word_cnt_q + CNT_W'(1);
    end
  end

  // Output stage: head of the FIFO, forced to zero when empty
  always_comb begin
    head_word = '0;
    head_len  = '0;
    if (head_vld) begin
      head_word = mem_word[rd_ptr];
      head_len  = mem_len[rd_ptr];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = head_vld;
  assign bus.out_word   = head_word;
  assign bus.out_len    = head_len;
  assign bus.out_xz     = head_vld && ((^head_word) === 1'bx);
  assign bus.word_count = word_cnt_q;
endmodule

// File: tb/tb_nibble_word_packer.sv
// Bench for nibble_word_packer: directed scenarios plus a randomized stream, checked
// by a scoreboard fed from a list-based packing model.
module tb_nibble_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_word_packer_if bus ();
  nibble_word_packer dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_word_q[$];
  logic [2:0]  exp_len_q[$];
  logic [3:0]  cur_nibs[$];
  logic [63:0] mdl_cnt = '0;
  bit          rdy_rand  = 1'b0;
  logic        rdy_fixed = 1'b1;
  bit          abort = 1'b0;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A word is the accepted nibbles in order from the top, zero-padded, closed by last or by the 4th nibble.
  task automatic model_accept(input logic [3:0] nib, input logic last);
    logic [15:0] w;
    cur_nibs.push_back(nib);
    if (last || cur_nibs.size() == 4) begin
      w = '0;
      for (int k = 0; k < cur_nibs.size(); k++) w[15-4*k -: 4] = cur_nibs[k];
      exp_word_q.push_back(w);
      exp_len_q.push_back(3'(cur_nibs.size()));
      cur_nibs.delete();
    end
  endtask

  task automatic send(input logic [3:0] nib, input logic last);
    bit ok;
    ok = 1'b0;
    if (!abort) begin
      bus.in_valid  = 1'b1;
      bus.in_nibble = nib;
      bus.in_last   = last;
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge clk);
        if (bus.in_ready) ok = 1'b1;
        else @(posedge clk);
      end
      if (ok) begin
        model_accept(nib, last);
        @(posedge clk);
        #1;
      end else begin
        n_tests++;
        n_fail++;
        abort = 1'b1;
        $display("FAIL accept_timeout: in_ready got 0 for 200 cycles, required 1 (nibble %h)", nib);
      end
      bus.in_valid  = 1'b0;
      bus.in_nibble = 4'($urandom);
      bus.in_last   = 1'($urandom);
    end
  endtask

  task automatic send4(input logic [15:0] w);
    for (int k = 0; k < 4; k++) send(w[15-4*k -: 4], 1'b0);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (exp_word_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still expected, required 0", exp_word_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cur_nibs.delete();
    @(negedge clk);
    check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_word_q.delete();
      exp_len_q.delete();
      mdl_cnt = '0;
    end else begin
      check("word_count", bus.word_count, mdl_cnt);
      if (bus.out_valid) begin
        if (exp_word_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h with out_valid=1, required no word", bus.out_word);
        end else begin
          check("out_word", 64'(bus.out_word), 64'(exp_word_q[0]));
          check("out_len", 64'(bus.out_len), 64'(exp_len_q[0]));
          check("out_xz", 64'(bus.out_xz), 64'($isunknown(exp_word_q[0])));
          if (bus.out_ready) begin
            void'(exp_word_q.pop_front());
            void'(exp_len_q.pop_front());
            mdl_cnt = mdl_cnt + 64'd1;
          end
        end
      end else begin
        check("idle_outputs", 64'({bus.out_len, bus.out_word, bus.out_xz}), 64'd0);
      end
    end
  end

  initial begin
    logic [3:0] xn;
    bus.in_valid  = 1'b0;
    bus.in_nibble = 4'h0;
    bus.in_last   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_word_count", bus.word_count, 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full word, one-cycle latency, count after pop
    send4(16'h1234);
    @(negedge clk);
    check("lat1_valid", 64'(bus.out_valid), 64'd1);
    check("lat1_word", 64'(bus.out_word), 64'h1234);
    check("lat1_len", 64'(bus.out_len), 64'd4);
    @(posedge clk);
    @(negedge clk);
    check("count_after_pop", bus.word_count, 64'd1);
    @(posedge clk);
    #1;

    // Short words
    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    @(negedge clk);
    check("short_word", 64'(bus.out_word), 64'hAB00);
    check("short_len", 64'(bus.out_len), 64'd2);
    @(posedge clk);
    #1;
    send(4'h5, 1'b1);
    @(negedge clk);
    check("fresh_word", 64'(bus.out_word), 64'h5000);
    check("fresh_len", 64'(bus.out_len), 64'd1);
    @(posedge clk);
    #1;
    send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0); send(4'h9, 1'b1);
    wait_drain();

    // Backpressure: two words buffered, producer stalled
    rdy_fixed = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_head", 64'(bus.out_word), 64'h0123);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("full_hold_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    for (int i = 8; i < 12; i++) send(4'(i), 1'b0);
    wait_drain();
    @(negedge clk);
    check("drain_count", bus.word_count, 64'd3);
    @(posedge clk);
    #1;

    // Four-state data
    xn = 4'bx1z0;
    send(4'h0, 1'b0); send(xn, 1'b0); send(4'h0, 1'b0); send(4'h0, 1'b0);
    @(negedge clk);
    check("xz_elem1", 64'(bus.out_word[11:8]), 64'(xn));
    check("xz_flag", 64'(bus.out_xz), 64'($isunknown(xn)));
    @(posedge clk);
    #1;
    send4(16'hC3D1);
    @(negedge clk);
    check("clean_xz", 64'(bus.out_xz), 64'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset mid-word with a word buffered
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    send4(16'h1234);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    do_reset();
    @(negedge clk);
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_count", bus.word_count, 64'd0);
    check("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    send4(16'h789A);
    @(negedge clk);
    check("post_rst_word", 64'(bus.out_word), 64'h789A);
    @(posedge clk);
    #1;
    wait_drain();

    // Counter wrap
    @(posedge clk);
    #1;
    force dut.word_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    mdl_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    @(negedge clk);
    check("count_preset", bus.word_count, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    send4(16'hFEDC);
    wait_drain();
    @(negedge clk);
    check("count_wrap", bus.word_count, 64'd0);
    @(posedge clk);
    #1;

    // Randomized stream with random backpressure and idle gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid  = 1'b0;
        bus.in_nibble = 4'($urandom);
        bus.in_last   = 1'($urandom);
        @(posedge clk);
        #1;
      end else begin
        send(4'($urandom), $urandom_range(0, 4) == 0);
      end
    end
    if (cur_nibs.size() != 0) send(4'($urandom), 1'b1);
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_word_packer.md
Name: nibble_word_packer

Overview:
- Upstream feeder stage that assembles a stream of 4-bit nibbles into 16-bit packed words laid out as [0:3][3:0], the word format consumed by the nibble-array word input of the downstream inversion/conversion stage.
- Handles short final words, buffers two finished words so packing continues while the consumer stalls, and keeps a 64-bit count of delivered words.
- Propagates X/Z on data bits unchanged and flags them on the output side.

Parameters:
- NPW, 4, nibbles per word; fixed at 4 in this revision.
- NW, 4, nibble width in bits.
- CNT_W, 64, width of the delivered-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_nibble is valid this cycle.
- in_ready  output  1  packer accepts a nibble this cycle.
- in_nibble  input  4  data nibble.
- in_last  input  1  accepted nibble closes the current word, even if the word is partial.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- out_word  output  16  packed word as [0:3][3:0]; element 0 is bits [15:12].
- out_len  output  3  number of real nibbles in out_word, range 1..4.
- out_xz  output  1  any bit of out_word is X or Z.
- word_count  output  64  number of completed output handshakes.

Behaviour:
- Reset: clk and rst as above, synchronous active-high. While rst=1 at a clock edge:
  - idx<=0 and the assembly register is cleared; any partial word is discarded.
  - FIFO is emptied; out_valid<=0, out_word<=0, out_len<=0, word_count<=0.
  - in_ready is 0 during any cycle in which rst is high.
- Accept: an accept occurs when in_valid && in_ready.
  - in_ready = !rst && (fifo_cnt != 2).
  - in_ready has no combinational path from out_ready; when the FIFO is full, in_ready stays 0 even if the FIFO pops that cycle.
- Packing:
  - The nibble accepted with idx=k lands in element k, i.e. bits [15-4k -: 4].
  - idx counts 0..3.
  - An accept with idx=3, or with in_last=1, completes the word:
    - the word is pushed into the FIFO that edge;
    - unfilled elements are padded with 4'b0000;
    - out_len = idx+1;
    - idx returns to 0.
  - Otherwise idx increments.
  - in_last at idx=3 gives a normal 4-nibble word; there is no extra empty word.
- FIFO: 2 entries, each {word, len}.
  - Push and pop may occur in the same cycle when fifo_cnt=1; the count is unchanged.
  - Pop = out_valid && out_ready.
  - out_valid = fifo_cnt != 0.
  - out_word and out_len show the head entry and hold stable while out_valid && !out_ready.
  - When the FIFO is empty, out_word = 0 and out_len = 0.
- Latency: the completing nibble accepted at edge N makes out_valid high in the cycle after N when the FIFO was empty. Minimum latency is 1 cycle; there is no combinational bypass.
- Throughput: one nibble per cycle sustained while out_ready=1, i.e. one word per 4 cycles.
- 4-state data:
  - Nibble bits are stored and forwarded bit-exact, X/Z included.
  - Pad bits are always 0.
  - out_xz = 1 iff out_valid and out_word contains any X/Z bit; evaluated combinationally on the head.
- word_count:
  - Increments by 1 on each pop; it is unsigned.
  - Wraps from 2^64-1 to 0 with no sticky flag.
- in_valid=0 with idx>0: the partial word is held indefinitely; there is no timeout.
- Inputs while in_valid=0 are ignored, including in_last.

Test Plan:
- Reset, then nibbles 1,2,3,4 on 4 consecutive cycles with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_word=16'h1234, out_len=4, out_xz=0. word_count reads 1 after the pop edge.
- Nibbles A,B with in_last=1 on B -> out_word=16'hAB00, out_len=2. The next nibble 5 starts a fresh word at bits [15:12].
- out_ready=0, stream 12 nibbles 0..B:
  - FIFO fills with 16'h0123 and 16'h4567; in_ready drops to 0 after the 8th accept.
  - Raising out_ready drains 0123, then 4567, then 89AB in order with no loss or duplication; word_count=3.
- Nibble 4'bx1z0 as element 1 of a full word 0,x1z0,0,0 -> out_word bits [11:8]=x1z0 exactly, out_xz=1. A following clean word gives out_xz=0.
- Assert rst for one cycle mid-word (idx=2) with one word in the FIFO:
  - next cycle out_valid=0, word_count=0, in_ready=1;
  - a following sequence 7,8,9,A yields 16'h789A, with no stale nibbles.
- Force word_count to 64'hFFFF_FFFF_FFFF_FFFF (forced via bench backdoor) and complete one pop -> word_count=0.
